stage0_pre_if: RTL and testbench

//  Pre-IF stage of the 5-stage LoongArch pipeline, directly upstream of stage1_IF.

---
 rtl/stage0_pre_if.sv | 139 +++++++++++++
 tb/tb_stage0_pre_if.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage0_pre_if.sv
// Pre-IF stage: owns the fetch PC, issues one request at a time on the sram-like
// inst bus and hands {adef, inst, pc} to IF. Optional same-cycle bypass: PREIF_BYPASS_EN.
module stage0_pre_if #(
    parameter logic [31:0] RESET_PC = 32'h1C000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_ex,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        fs_allow_in,
    output logic        pfs_to_fs_valid,
    output logic [64:0] pfs_to_fs_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] inst_buf_reg;
    logic        adef_buf_reg;
    logic        cancel_reg;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        pc_misaligned;
    logic        req_fire;
    logic        data_accept;
    logic        bypass_valid;
    logic        bypass_take;
    logic        hold_valid;

    assign redirect = wb_ex | ertn_flush | br_taken;

    always_comb begin
        redirect_target = br_target;
        if (wb_ex)
            redirect_target = ex_entry;
        else if (ertn_flush)
            redirect_target = ertn_pc;
    end

    assign pc_misaligned = |pc_reg[1:0];
    assign data_accept   = (state_reg == S_WAIT) && inst_sram_data_ok && !cancel_reg && !redirect;

`ifdef PREIF_BYPASS_EN
    assign bypass_valid = data_accept;
`else
    assign bypass_valid = 1'b0;
`endif
    assign bypass_take = bypass_valid && fs_allow_in;
    assign hold_valid  = (state_reg == S_HOLD) && !redirect;

    assign pfs_to_fs_valid = !reset && (hold_valid || bypass_valid);
    assign pfs_to_fs_bus   = bypass_valid ? {1'b0, inst_sram_rdata, pc_reg}
                                          : {adef_buf_reg, inst_buf_reg, pc_reg};

    // Misaligned PCs never reach the bus; they turn into an adef entry instead.
    assign inst_sram_req   = !reset && (state_reg == S_REQ) && !pc_misaligned;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_addr  = pc_reg;
    assign inst_sram_wdata = 32'h0;

    assign req_fire = inst_sram_req && inst_sram_addr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_REQ;
            pc_reg       <= RESET_PC;
            cancel_reg   <= 1'b0;
            inst_buf_reg <= 32'h0;
            adef_buf_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (redirect) begin
                        pc_reg <= redirect_target;
                        // An already-accepted request must still be drained, but its data is dead.
                        if (req_fire) begin
                            state_reg  <= S_WAIT;
                            cancel_reg <= 1'b1;
                        end
                    end else if (pc_misaligned) begin
                        inst_buf_reg <= 32'h0;
                        adef_buf_reg <= 1'b1;
                        state_reg    <= S_HOLD;
                    end else if (req_fire) begin
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        if (cancel_reg || redirect) begin
                            cancel_reg <= 1'b0;
                            state_reg  <= S_REQ;
                            if (redirect)
                                pc_reg <= redirect_target;
                        end else if (bypass_take) begin
                            pc_reg    <= pc_reg + 32'd4;
                            state_reg <= S_REQ;
                        end else begin
                            inst_buf_reg <= inst_sram_rdata;
                            adef_buf_reg <= 1'b0;
                            state_reg    <= S_HOLD;
                        end
                    end else if (redirect) begin
                        pc_reg     <= redirect_target;
                        cancel_reg <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc_reg    <= redirect_target;
                        state_reg <= S_REQ;
                    end else if (fs_allow_in) begin
                        pc_reg    <= pc_reg + 32'd4;
                        state_reg <= S_REQ;
                    end
                end
                default: state_reg <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage0_pre_if.sv
// Self-checking bench for stage0_pre_if: table-driven fetches plus hand-written
// redirect, adef, wrap and reset sequences, checked through an expected-transfer queue.
module tb_stage0_pre_if;

    logic        clk;
    logic        reset;
    logic        wb_ex;
    logic [31:0] ex_entry;
    logic        ertn_flush;
    logic [31:0] ertn_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_allow_in;
    logic        pfs_to_fs_valid;
    logic [64:0] pfs_to_fs_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    stage0_pre_if dut (
        .clk               (clk),
        .reset             (reset),
        .wb_ex             (wb_ex),
        .ex_entry          (ex_entry),
        .ertn_flush        (ertn_flush),
        .ertn_pc           (ertn_pc),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .fs_allow_in       (fs_allow_in),
        .pfs_to_fs_valid   (pfs_to_fs_valid),
        .pfs_to_fs_bus     (pfs_to_fs_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] rdata;
        int          ok_delay;
        int          data_gap;
        int          hold;
    } vec_t;

    vec_t        vecs[5];
    logic [64:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Let combinational outputs settle after inputs change; score any transfer to IF.
    task automatic settle();
        logic [64:0] e;
        #1;
        if (pfs_to_fs_valid && fs_allow_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer_unexpected: got bus=%h, required no transfer", pfs_to_fs_bus);
            end else begin
                e = exp_q.pop_front();
                $display("xfer adef=%b inst=%h pc=%h", pfs_to_fs_bus[64], pfs_to_fs_bus[63:32], pfs_to_fs_bus[31:0]);
                chk("xfer_bus", pfs_to_fs_bus, e);
            end
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic accept(input logic [31:0] addr, input int ok_delay);
        bit done = 0;
        int n = 0;
        while (!done) begin
            inst_sram_addr_ok = (n >= ok_delay);
            settle();
            if (inst_sram_req && inst_sram_addr_ok) begin
                $display("req  addr=%h", inst_sram_addr);
                chk("req_addr", {33'h0, inst_sram_addr}, {33'h0, addr});
                done = 1;
            end else if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL req_timeout: got no accepted request, required req addr=%h", addr);
                done = 1;
            end
            n++;
            next();
        end
        inst_sram_addr_ok = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata, input int gap);
        for (int i = 0; i < gap; i++) begin
            settle();
            chk("wait_no_req", {64'h0, inst_sram_req}, 65'h0);
            next();
        end
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = rdata;
        settle();
        chk("data_no_req", {64'h0, inst_sram_req}, 65'h0);
`ifndef PREIF_BYPASS_EN
        chk("data_cycle_not_valid", {64'h0, pfs_to_fs_valid}, 65'h0);
`endif
        next();
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = $urandom;
    endtask

    task automatic drain(input int hold);
        fs_allow_in = 1'b0;
        for (int i = 0; i < hold; i++) begin
            settle();
            chk("hold_valid", {64'h0, pfs_to_fs_valid}, 65'h1);
            chk("hold_no_req", {64'h0, inst_sram_req}, 65'h0);
            if (exp_q.size() != 0)
                chk("hold_bus", pfs_to_fs_bus, exp_q[0]);
            next();
        end
        fs_allow_in = 1'b1;
        settle();
        chk("drain_valid", {64'h0, pfs_to_fs_valid}, 65'h1);
        next();
        fs_allow_in = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h02800000, 0, 0, 0};
        vecs[1] = '{32'h12345678, 2, 1, 4};
        vecs[2] = '{32'hFFFFFFFF, 1, 3, 1};
        vecs[3] = '{32'h00000000, 0, 0, 0};
        vecs[4] = '{32'hDEADBEEF, 3, 2, 2};

        reset = 1'b1; wb_ex = 1'b0; ex_entry = 32'h0; ertn_flush = 1'b0; ertn_pc = 32'h0;
        br_taken = 1'b0; br_target = 32'h0; fs_allow_in = 1'b0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;

        next();
        for (int i = 0; i < 3; i++) begin
            fs_allow_in = 1'b1;
            inst_sram_addr_ok = 1'b1;
            settle();
            chk("reset_no_req", {64'h0, inst_sram_req}, 65'h0);
            chk("reset_no_valid", {64'h0, pfs_to_fs_valid}, 65'h0);
            next();
        end
        reset = 1'b0; fs_allow_in = 1'b0; inst_sram_addr_ok = 1'b0;

        // Table-driven sequential fetches.
        exp_pc = 32'h1C000000;
        for (int i = 0; i < 5; i++) begin
            accept(exp_pc, vecs[i].ok_delay);
            exp_q.push_back({1'b0, vecs[i].rdata, exp_pc});
            respond(vecs[i].rdata, vecs[i].data_gap);
            drain(vecs[i].hold);
            exp_pc = exp_pc + 32'd4;
        end

`ifdef PREIF_BYPASS_EN
        // Same-cycle bypass: valid with data_ok, next request right after.
        accept(exp_pc, 0);
        exp_q.push_back({1'b0, 32'hCAFEF00D, exp_pc});
        inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hCAFEF00D; fs_allow_in = 1'b1;
        settle();
        chk("bypass_valid", {64'h0, pfs_to_fs_valid}, 65'h1);
        next();
        inst_sram_data_ok = 1'b0; fs_allow_in = 1'b0;
        exp_pc = exp_pc + 32'd4;
`endif

        // Branch during WAIT: response is discarded, next request at target.
        accept(exp_pc, 0);
        br_taken = 1'b1; br_target = 32'h1C000100;
        settle();
        chk("wait_br_no_req", {64'h0, inst_sram_req}, 65'h0);
        next();
        br_taken = 1'b0;
        settle();
        chk("cancel_no_req", {64'h0, inst_sram_req}, 65'h0);
        next();
        inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h11111111; fs_allow_in = 1'b1;
        settle();
        chk("cancel_data_dropped", {64'h0, pfs_to_fs_valid}, 65'h0);
        next();
        inst_sram_data_ok = 1'b0; fs_allow_in = 1'b0;
        accept(32'h1C000100, 0);

        // Exception and branch together in HOLD: exception wins, no transfer.
        respond(32'h22222222, 0);
        fs_allow_in = 1'b1; wb_ex = 1'b1; ex_entry = 32'h1C008000;
        br_taken = 1'b1; br_target = 32'h1C000200;
        settle();
        chk("hold_redirect_no_valid", {64'h0, pfs_to_fs_valid}, 65'h0);
        next();
        fs_allow_in = 1'b0; wb_ex = 1'b0; br_taken = 1'b0;
        accept(32'h1C008000, 0);
        exp_q.push_back({1'b0, 32'h33333333, 32'h1C008000});
        respond(32'h33333333, 0);
        drain(0);

        // Unaccepted request withdrawn by a branch to a misaligned target.
        br_taken = 1'b1; br_target = 32'h1C000102;
        settle();
        next();
        br_taken = 1'b0;
        settle();
        chk("adef_no_req", {64'h0, inst_sram_req}, 65'h0);
        next();
        exp_q.push_back({1'b1, 32'h0, 32'h1C000102});
        drain(2);
        settle();
        chk("adef2_no_req", {64'h0, inst_sram_req}, 65'h0);
        next();
        exp_q.push_back({1'b1, 32'h0, 32'h1C000106});
        drain(0);

        // Redirect from misaligned REQ, then ertn+branch while a request is accepted.
        br_taken = 1'b1; br_target = 32'h1C000300;
        settle();
        chk("misaligned_redirect_no_req", {64'h0, inst_sram_req}, 65'h0);
        next();
        br_taken = 1'b0;
        ertn_flush = 1'b1; ertn_pc = 32'h1C000400;
        br_taken = 1'b1; br_target = 32'h1C000500;
        accept(32'h1C000300, 0);
        ertn_flush = 1'b0; br_taken = 1'b0;
        inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h44444444; fs_allow_in = 1'b1;
        settle();
        chk("req_cancel_dropped", {64'h0, pfs_to_fs_valid}, 65'h0);
        next();
        inst_sram_data_ok = 1'b0; fs_allow_in = 1'b0;
        accept(32'h1C000400, 0);
        exp_q.push_back({1'b0, 32'h55555555, 32'h1C000400});
        respond(32'h55555555, 1);
        drain(0);

        // PC wrap at the top of the address space.
        br_taken = 1'b1; br_target = 32'hFFFFFFFC;
        settle();
        next();
        br_taken = 1'b0;
        accept(32'hFFFFFFFC, 0);
        exp_q.push_back({1'b0, 32'h66666666, 32'hFFFFFFFC});
        respond(32'h66666666, 0);
        drain(1);
        accept(32'h00000000, 0);

        // Reset while WAIT abandons the request and restarts at RESET_PC.
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("wait_reset_no_req", {64'h0, inst_sram_req}, 65'h0);
            chk("wait_reset_no_valid", {64'h0, pfs_to_fs_valid}, 65'h0);
            next();
        end
        reset = 1'b0;
        accept(32'h1C000000, 0);

        chk("queue_empty", 65'(exp_q.size()), 65'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
